pixel_compositor: RTL

Parametrised, pipelined successor to the top-level colour mux that sits between the per-pixel layer generators (debug overlay, map overlay, wall renderer, background) and the VGA pins. It merges N prioritised layers into one registered RGB output. It delays sync/blanking so that they stay aligned with colour. It adds per-frame layer blinking and a global dim mode that the combinational mux lacks.

---
 rtl/pixel_compositor_pkg.sv | 24 ++
 rtl/pixel_compositor_sync_delay_line.sv | 40 ++++
 rtl/pixel_compositor.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pixel_compositor_pkg.sv
// Shared definitions for the pixel compositor: default geometry, frame counter
// width, sync bundle type and the colour channel width helper.
package pixel_compositor_pkg;

    localparam int unsigned DEFAULT_LAYERS      = 4;
    localparam int unsigned DEFAULT_CW          = 6;
    localparam int unsigned DEFAULT_LAT         = 2;
    localparam int unsigned DEFAULT_BLINK_SHIFT = 4;
    localparam int unsigned FRAME_W             = 8;

    // Active-low sync pair carried through the output delay line
    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1};

    // Width of one R, G or B channel for a packed RGB colour of cw bits
    function automatic int unsigned ch_width(input int unsigned cw);
        return cw / 3;
    endfunction

endpackage

// File: rtl/pixel_compositor_sync_delay_line.sv
// Fixed-depth register delay line with an asynchronous reset to a
// configurable idle value. DEPTH=0 degenerates to a wire.
module pixel_compositor_sync_delay_line #(
    parameter int unsigned     DEPTH = 1,
    parameter int unsigned     WIDTH = 1,
    parameter logic [WIDTH-1:0] IDLE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = clk ^ reset_n;
            assign q = d;
        end else begin : g_regs
            logic [WIDTH-1:0] stages [DEPTH];

            // Shift the bundle one stage per clock; reset fills with idle
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stages[i] <= IDLE;
                    end
                end else begin
                    stages[0] <= d;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign q = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/pixel_compositor.sv
// Prioritised layer compositor driving the VGA pins: picks the highest
// priority visible layer (or background), applies blanking and dim, and
// delays sync so that colour and sync leave with identical latency.
// Optional feature macro: PIXEL_COMPOSITOR_BLINK_EN enables per-frame layer
// blinking driven by frame_count[BLINK_SHIFT].
module pixel_compositor
    import pixel_compositor_pkg::*;
#(
    parameter int unsigned LAYERS      = DEFAULT_LAYERS,
    parameter int unsigned CW          = DEFAULT_CW,
    parameter int unsigned LAT         = DEFAULT_LAT,
    parameter int unsigned BLINK_SHIFT = DEFAULT_BLINK_SHIFT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 visible_in,
    input  logic [LAYERS-1:0]    layer_en,
    input  logic [LAYERS*CW-1:0] layer_rgb,
    input  logic [LAYERS-1:0]    layer_blink,
    input  logic [CW-1:0]        bg_rgb,
    input  logic                 dim,
    output logic                 hsync_n,
    output logic                 vsync_n,
    output logic [CW-1:0]        rgb,
    output logic [FRAME_W-1:0]   frame_count
);

    localparam int unsigned CH = ch_width(CW);

    logic               vsync_q;
    logic [FRAME_W-1:0] frame_q;
    logic [LAYERS-1:0]  eff_c;
    logic [CW-1:0]      sel_c;
    logic [CW-1:0]      pix_c;
    logic [CW-1:0]      rgb_s1;
    sync_t              sync_d;
    sync_t              sync_q;

    // Count vsync rising edges; the counter also paces blinking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q <= 1'b0;
            frame_q <= '0;
        end else begin
            vsync_q <= vsync_in;
            if (vsync_in && !vsync_q) begin
                frame_q <= frame_q + FRAME_W'(1);
            end
        end
    end

    assign frame_count = frame_q;

`ifdef PIXEL_COMPOSITOR_BLINK_EN
    logic blink_off;
    assign blink_off = frame_q[BLINK_SHIFT];
    assign eff_c = layer_en & ~({LAYERS{blink_off}} & layer_blink);
`else
    logic unused_blink;
    assign unused_blink = ^layer_blink;
    assign eff_c = layer_en;
`endif

    // Lowest-index effective layer wins, background otherwise
    always_comb begin
        sel_c = bg_rgb;
        for (int i = int'(LAYERS) - 1; i >= 0; i--) begin
            if (eff_c[i]) begin
                sel_c = layer_rgb[i*CW +: CW];
            end
        end
    end

    // Per-channel halving for dim, then force black outside active video
    always_comb begin
        pix_c = sel_c;
        if (dim) begin
            for (int unsigned c = 0; c < 3; c++) begin
                pix_c[c*CH +: CH] = sel_c[c*CH +: CH] >> 1;
            end
        end
        if (!visible_in) begin
            pix_c = '0;
        end
    end

    // First pipeline stage holds the composited colour
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_s1 <= '0;
        end else begin
            rgb_s1 <= pix_c;
        end
    end

    pixel_compositor_sync_delay_line #(
        .DEPTH (LAT - 1),
        .WIDTH (CW),
        .IDLE  ('0)
    ) u_colour_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rgb_s1),
        .q       (rgb)
    );

    assign sync_d = '{hsync_n: ~hsync_in, vsync_n: ~vsync_in};

    pixel_compositor_sync_delay_line #(
        .DEPTH (LAT),
        .WIDTH ($bits(sync_t)),
        .IDLE  (SYNC_IDLE)
    ) u_sync_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sync_d),
        .q       (sync_q)
    );

    assign hsync_n = sync_q.hsync_n;
    assign vsync_n = sync_q.vsync_n;

endmodule
